// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   IDX_W       width of a key index / legend code
//   NUM_KEYS    number of keys in the matrix
//   kp_state_e  accept FSM state (idle / key held)
//   kp_legend() maps a row-major key index to its printed hex legend
package keypad_pkg;

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned NUM_KEYS = 16;

    typedef enum logic [0:0] {
        StIdle,
        StHeld
    } kp_state_e;

    // Row-major legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    function automatic logic [IDX_W-1:0] kp_legend(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] code;
        code = '0;
        unique case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'h0;
            4'd13: code = 4'hF;
            4'd14: code = 4'hE;
            4'd15: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: whole-scan debouncer for the keypad scanner.
// Ports:
//   clk            system clock
//   rst_l          synchronous active-high reset
//   scan_end       one-cycle strobe marking the end of a full scan
//   res_pressed    any key seen during the scan just completed
//   res_idx        lowest pressed key index of that scan
//   stable         pulse: result has now repeated DEBOUNCE_SCANS times
//   stable_pressed / stable_idx   the result qualified by stable
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_end,
    input  logic             res_pressed,
    input  logic [IDX_W-1:0] res_idx,
    output logic             stable,
    output logic             stable_pressed,
    output logic [IDX_W-1:0] stable_idx
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

    logic [IDX_W:0]  result;
    logic [IDX_W:0]  prev_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign result = {res_pressed, res_idx};

    // Saturating run-length count of identical scan results.
    always_comb begin
        cnt_d = cnt_q;
        if (result == prev_q) begin
            if (cnt_q != CntW'(DEBOUNCE_SCANS)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_l) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else if (scan_end) begin
            prev_q <= result;
            cnt_q  <= cnt_d;
        end
    end

    assign stable         = scan_end && (cnt_d == CntW'(DEBOUNCE_SCANS));
    assign stable_pressed = res_pressed;
    assign stable_idx     = res_idx;

endmodule

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: column-multiplexed 4x4 matrix keypad scanner.
// Ports:
//   clk        system clock, all logic on rising edge
//   rst_l      synchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, active-low one-hot, registered
//   key_code   legend of the last accepted press, held until the next one
//   key_valid  one-cycle pulse when a new press is accepted
//   key_down   high while the accepted key stays stably pressed
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [IDX_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);

    logic [DivW-1:0]     div_cnt_q;
    logic [1:0]          col_q;
    logic [3:0]          row_meta_q;
    logic [3:0]          row_sync_q;
    logic [NUM_KEYS-1:0] snap_q;
    logic [NUM_KEYS-1:0] snap_d;
    logic                sample;
    logic                scan_end;
    logic                res_pressed;
    logic [IDX_W-1:0]    res_idx;
    logic                stable;
    logic                stable_pressed;
    logic [IDX_W-1:0]    stable_idx;
    kp_state_e           state_q;

    // Sample on the last dwell cycle so the rows have settled through the synchronizer.
    assign sample   = (div_cnt_q == DivW'(SCAN_DIV - 1));
    assign scan_end = sample && (col_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst_l) begin
            div_cnt_q  <= '0;
            col_q      <= 2'd0;
            col_out    <= 4'b1110;
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            snap_q     <= '0;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            snap_q     <= snap_d;
            if (sample) begin
                div_cnt_q <= '0;
                col_q     <= col_q + 2'd1;
                col_out   <= ~(4'b0001 << (col_q + 2'd1));
            end else begin
                div_cnt_q <= div_cnt_q + DivW'(1);
            end
        end
    end

    // Snapshot bit {row, col} set when that row reads low while col is driven.
    always_comb begin
        snap_d = snap_q;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_q}] = ~row_sync_q[r];
            end
        end
    end

    // The scan-end result includes the column 3 bits sampled in this same cycle.
    assign res_pressed = |snap_d;

    always_comb begin
        res_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snap_d[i]) begin
                res_idx = IDX_W'(i);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk           (clk),
        .rst_l         (rst_l),
        .scan_end      (scan_end),
        .res_pressed   (res_pressed),
        .res_idx       (res_idx),
        .stable        (stable),
        .stable_pressed(stable_pressed),
        .stable_idx    (stable_idx)
    );

    // Accept FSM; a different key becoming stable while held is ignored.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            state_q   <= StIdle;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (stable && stable_pressed) begin
                        state_q   <= StHeld;
                        key_code  <= kp_legend(stable_idx);
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                    end
                end
                StHeld: begin
                    if (stable && !stable_pressed) begin
                        state_q  <= StIdle;
                        key_down <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4: directed self-checking bench for keypad_scan_4x4
// with SCAN_DIV=8, DEBOUNCE_SCANS=3 and a behavioural keypad matrix model.
module tb_keypad_scan_4x4;

    localparam int unsigned ScanDiv = 8;
    localparam int unsigned DbScans = 3;
    localparam int          Scan    = 32;
    localparam int          LatMax  = (DbScans + 1) * Scan + 3;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys = '0;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int dbl = 0;
    int code_viol = 0;
    int kd_hi = 0;
    int kd_lo = 0;
    int lat = 0;
    int p0 = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] last_code = 4'h0;
    logic [3:0] exp_col;

    keypad_scan_4x4 #(
        .SCAN_DIV      (ScanDiv),
        .DEBOUNCE_SCANS(DbScans)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Row r pulled low iff a pressed key in row r sits on a driven (low) column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    // Pulse bookkeeping: count pulses, back-to-back pulses, code changes without a pulse.
    always @(negedge clk) begin
        if (key_valid) begin
            pulses = pulses + 1;
            if (prev_valid) dbl = dbl + 1;
        end
        if (!rst_l && (key_code !== last_code) && !key_valid) code_viol = code_viol + 1;
        prev_valid = key_valid;
        last_code  = key_code;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles, tallying key_down high and low cycles.
    task automatic run_obs(input int n);
        repeat (n) begin
            @(negedge clk);
            if (key_down) kd_hi++;
            else kd_lo++;
        end
    endtask

    task automatic wait_pulse();
        lat = 0;
        while (!key_valid && lat < LatMax + 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_col", 32'(col_out), 32'(4'b1110));
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_down", 32'(key_down), 32'h0);
        rst_l = 1'b0;

        // Idle column sequence, 8 cycles per column
        for (int k = 0; k < 40; k++) begin
            exp_col = ~(4'b0001 << ((k / 8) % 4));
            chk($sformatf("col_seq%0d", k), 32'(col_out), 32'(exp_col));
            @(negedge clk);
        end
        chk("idle_pulses", 32'(pulses), 32'h0);
        chk("idle_down", 32'(key_down), 32'h0);
        chk("idle_code", 32'(key_code), 32'h0);

        // Bounce on (0,1): 2 scans pressed, 1 released, three times
        p0 = pulses;
        kd_hi = 0;
        repeat (3) begin
            keys = 16'h0002;
            run_obs(2 * Scan);
            keys = 16'h0000;
            run_obs(Scan);
        end
        run_obs(2 * Scan);
        chk("bounce_pulses", 32'(pulses - p0), 32'h0);
        chk("bounce_down", 32'(kd_hi), 32'h0);

        // Hold (1,2) -> legend 6
        p0 = pulses;
        keys = 16'h0040;
        wait_pulse();
        chk("k6_seen", 32'(key_valid), 32'h1);
        chk("k6_lat", 32'(lat <= LatMax), 32'h1);
        chk("k6_code", 32'(key_code), 32'h6);
        chk("k6_down", 32'(key_down), 32'h1);
        kd_lo = 0;
        run_obs(10 * Scan - lat);
        chk("k6_down_held", 32'(kd_lo), 32'h0);
        chk("k6_one_pulse", 32'(pulses - p0), 32'h1);

        // Release, then hold (3,0) -> legend 0
        keys = 16'h0000;
        p0 = pulses;
        cyc(4 * Scan);
        chk("rel6_down", 32'(key_down), 32'h0);
        chk("rel6_pulses", 32'(pulses - p0), 32'h0);
        keys = 16'h1000;
        wait_pulse();
        chk("k0_seen", 32'(key_valid), 32'h1);
        chk("k0_code", 32'(key_code), 32'h0);
        chk("k0_down", 32'(key_down), 32'h1);
        cyc(4);
        chk("k0_one_pulse", 32'(pulses - p0), 32'h1);

        // Two keys (0,0)+(2,3) -> lowest index wins (legend 1); then rollover to (2,3)
        keys = 16'h0000;
        cyc(4 * Scan);
        chk("rel0_down", 32'(key_down), 32'h0);
        p0 = pulses;
        keys = 16'h0801;
        wait_pulse();
        chk("k1_seen", 32'(key_valid), 32'h1);
        chk("k1_code", 32'(key_code), 32'h1);
        keys = 16'h0800;
        kd_lo = 0;
        run_obs(5 * Scan);
        chk("roll_down", 32'(kd_lo), 32'h0);
        chk("roll_pulses", 32'(pulses - p0), 32'h1);
        chk("roll_code", 32'(key_code), 32'h1);

        // Reset while "6" is held and accepted
        keys = 16'h0000;
        cyc(4 * Scan);
        keys = 16'h0040;
        wait_pulse();
        chk("pre_rst_code", 32'(key_code), 32'h6);
        cyc(2 * Scan);
        rst_l = 1'b1;
        cyc(2);
        chk("mid_rst_col", 32'(col_out), 32'(4'b1110));
        chk("mid_rst_code", 32'(key_code), 32'h0);
        chk("mid_rst_valid", 32'(key_valid), 32'h0);
        chk("mid_rst_down", 32'(key_down), 32'h0);
        rst_l = 1'b0;
        p0 = pulses;
        wait_pulse();
        chk("post_rst_seen", 32'(key_valid), 32'h1);
        chk("post_rst_lat", 32'(lat <= LatMax), 32'h1);
        chk("post_rst_code", 32'(key_code), 32'h6);
        cyc(4);
        chk("post_rst_pulses", 32'(pulses - p0), 32'h1);

        chk("no_double_pulse", 32'(dbl), 32'h0);
        chk("code_only_with_valid", 32'(code_viol), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_4x4.md
# keypad_scan_4x4

Scans a 4x4 matrix keypad (Pmod KYPD wiring) by driving one column low at a time and sampling the four row inputs. It debounces the result over whole scans and reports each accepted press once as a hex legend code with a one-cycle strobe. It is the input-side counterpart of the multiplexed 4-digit display driver: the same column-time-multiplexing idea, reversed. Its `key_code` is 4 bits, so it can feed a display digit directly.

## Interface
- `SCAN_DIV`, default 25000: clk cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-scan results required to accept a change. Must be ≥ 1.

Ports:
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst_l` input 1: reset, synchronous, active-high. Asserted = 1.
- `row_in` input 4: keypad rows, active-low (board pull-ups), asynchronous.
- `col_out` output 4: column drive, active-low one-hot.
- `key_code` output 4: legend value of the accepted key; held until the next accepted press.
- `key_valid` output 1: one-cycle pulse when a new press is accepted.
- `key_down` output 1: level, 1 while an accepted key remains stably pressed.

## Operation
- `row_in` passes through a 2-flop synchronizer before any use.
- Divider counter `div_cnt` runs 0..SCAN_DIV-1. Column index `col` (2 bits) advances when `div_cnt` = SCAN_DIV-1 and wraps 3→0.
- `col_out` = ~(1 << col), registered.
- The synchronized rows are sampled when `div_cnt` = SCAN_DIV-1, i.e. the last cycle of each column's dwell. Bit (row*4+col) of a 16-bit snapshot is set when `row_sync[row]` = 0.
- Scan end = the sample cycle with `col` = 3. At scan end the scan result is formed:
  - `pressed` = |snapshot.
  - `idx` = lowest set index. Multiple keys resolve to the lowest index; if nothing is pressed, `idx` = 0.
- Debounce:
  - If the result `{pressed, idx}` equals `prev`, the count `cnt` increments, saturating at DEBOUNCE_SCANS.
  - Otherwise `prev` takes the new result and `cnt` = 1.
  - The result is stable at a scan end where `cnt` becomes equal to DEBOUNCE_SCANS.
- FSM states IDLE and HELD:
  - IDLE → HELD on a stable result with `pressed` = 1. On the next cycle, `key_code` = legend(`idx`), `key_valid` = 1 for one cycle, and `key_down` = 1.
  - HELD → IDLE on a stable result with `pressed` = 0. On the next cycle, `key_down` = 0.
  - In HELD, a stable but different pressed key (rollover) is ignored: no pulse and no code change. A new press requires passing through IDLE.
- Legend, indexed row-major:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- Reset values: `div_cnt` = 0, `col` = 0, `col_out` = 4'b1110, snapshot = 0, `prev` = 0, `cnt` = 0, state IDLE, `key_code` = 0, `key_valid` = 0, `key_down` = 0.
- Reset mid-press clears all state. A key still held after reset is re-debounced and produces a fresh `key_valid`.

## Timing
- Column dwell is SCAN_DIV cycles; a full scan is 4·SCAN_DIV cycles.
- `col_out` changes on the cycle after the `div_cnt` wrap.
- Row sampling happens SCAN_DIV-1 cycles after the column change, so at least SCAN_DIV-3 cycles of settling remain after the synchronizer.
- Press latency: at most (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 cycles from a clean press to `key_valid`.
- `key_valid` is never asserted on two consecutive cycles.
- `key_code` changes only in the same cycle `key_valid` asserts.

## Structure
- Package `keypad_pkg`:
  - state enum (IDLE, HELD);
  - a 16-entry legend constant array / function `kp_legend(idx)`;
  - localparam widths (`IDX_W` = 4).
- Sub-module `keypad_debounce`: holds `prev`/`cnt`, compares against the scan-end result, and outputs a `stable` pulse plus the stable result. Parameter: DEBOUNCE_SCANS.
- The top level owns the divider, column counter, synchronizer, snapshot/priority encode, FSM and output registers.

## Test plan
The bench uses SCAN_DIV=8, DEBOUNCE_SCANS=3 (a scan is 32 cycles). The keypad model drives `row_in[r]` = 0 iff key (r,c) is pressed and `col_out[c]` = 0.

- Reset, no keys → `col_out` sequence 1110, 1101, 1011, 0111, each held 8 cycles; `key_valid` never 1; `key_down` = 0; `key_code` = 0.
- Hold row 1 col 2 for 10 scans → exactly one `key_valid` pulse with `key_code` = 6, within (3+1)·32+3 cycles; `key_down` = 1 throughout; no further pulses.
- Press row 0 col 1 for 2 scans, release 1 scan, repeat 3 times → no `key_valid`; `key_down` stays 0.
- After the held "6", release for 4 scans and then hold row 3 col 0 → `key_down` falls, then a single pulse with `key_code` = 0.
- Hold row 0 col 0 and row 2 col 3 together → one pulse with `key_code` = 1. Then release row 0 col 0 while still holding row 2 col 3 → no new pulse (rollover ignored).
- Assert `rst_l` for 2 cycles while "6" is held and accepted → the next cycle shows all reset values; a new `key_valid` with `key_code` = 6 follows after re-debounce.
